seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Single clock domain; reset synchronous, active-low; no other reset or clock.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Rst_n  input  1  synchronous active-low reset, sampled on Clk rising edge.
REQ-004 Start  input  1  request; accepted only in IDLE or DONE.
REQ-005 Dividend  input  8  unsigned dividend, sampled on accepting edge.
REQ-006 Divisor  input  8  unsigned divisor, sampled on accepting edge.
REQ-007 Quotient  output  8  registered quotient of last completed operation.
REQ-008 Remainder  output  8  registered remainder of last completed operation.
REQ-009 Busy  output  1  high while in RUN.
REQ-010 Done  output  1  one-cycle pulse; Quotient/Remainder valid from this cycle.
REQ-011 Div_by_zero  output  1  present only with DIV_ZERO_FLAG_EN; high with Done when Divisor was 0.

Function
REQ-012 FSM states IDLE, RUN, DONE; IDLE->RUN on accepted Start; RUN->DONE after 8th iteration; DONE->IDLE on the next edge unless Start=1 (then DONE->RUN).
REQ-013 Start in RUN ignored; operands not resampled; no error flag.
REQ-014 Accepting edge: latch operands into working registers, clear 8-bit partial remainder, iteration counter=0, Busy=1 from the next cycle.
REQ-015 Each RUN edge is one restoring step: shift {partial remainder, dividend MSB} left; 9-bit trial = shifted value minus {0,Divisor}; if no borrow, keep difference and shift in quotient bit 1; else restore and shift in 0.
REQ-016 Latency: Done=1 in the cycle after the 8th RUN edge, i.e. 9 edges after the accepting edge; Busy low in that cycle.
REQ-017 Quotient/Remainder update only on the edge entering DONE; held stable during RUN and IDLE until the next completion.
REQ-018 Arithmetic unsigned, 8-bit; trial subtraction 9-bit so 255/1 and 255/255 are exact; no overflow possible.
REQ-019 Back-to-back: Start in DONE accepted on same edge; Done deasserts, Busy rises next cycle.

Reset
REQ-020 Rst_n=0 at any edge: state=IDLE, Quotient=0, Remainder=0, Busy=0, Done=0, Div_by_zero=0, working registers and counter=0.
REQ-021 Rst_n has priority over Start; reset mid-RUN aborts the operation and produces no Done.

Configuration
REQ-022 Macro DIV_ZERO_FLAG_EN defined: Div_by_zero port exists; Divisor=0 at accepting edge goes directly to DONE (Done one edge later), Quotient=8'hFF, Remainder=Dividend, Div_by_zero=1 for the Done cycle only.
REQ-023 Macro undefined: no Div_by_zero port; Divisor=0 runs the normal 8-step algorithm, giving Quotient=8'hFF, Remainder=Dividend with standard latency.

Structure
REQ-024 Shared package div_pkg holds the data width (8), iteration count (8), counter width (3) and FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
REQ-025 One sub-module trial_subtractor: combinational 9-bit minuend minus 8-bit divisor, outputs 8-bit difference and borrow; built from the team's existing gate-level full-adder cells with B inverted and carry-in 1.

Verification
REQ-026 Reset held 3 cycles, then released -> all outputs 0, Busy=0, Done=0.
REQ-027 Start with Dividend=200, Divisor=7 -> Done exactly 9 edges later with Quotient=28 (8'h1C), Remainder=4; Busy high for 8 cycles.
REQ-028 Sequential ops 255/1, 5/9 and 255/255 -> (8'hFF,0), (0,5) and (1,0).
REQ-029 Dividend=8'h42, Divisor=0 -> Quotient=8'hFF, Remainder=8'h42; with DIV_ZERO_FLAG_EN, Done one edge after accept and Div_by_zero=1; without it, Done after 9 edges.
REQ-030 Start 100/3, Rst_n=0 on the 4th RUN edge -> IDLE, outputs 0, no Done; next Start 100/3 -> Quotient=33, Remainder=1.
REQ-031 Start held high through RUN with changing operands -> only the first operands used; Start=1 in DONE with 50/6 -> second result Quotient=8, Remainder=2, 9 edges later.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// ============================================================================
//  Module      : div_pkg (package)
//  Description : Shared widths, iteration count and FSM state encoding for
//                the sequential restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int c_DATA_W = 8;   // operand / result width
    localparam int c_ITER   = 8;   // restoring steps per division
    localparam int c_CNT_W  = 3;   // iteration counter width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : div_pkg

`default_nettype wire

// File: rtl/seq_divider_trial_subtractor.sv
// ============================================================================
//  Module      : trial_subtractor (+ full_adder cell)
//  Description : Combinational 9-bit minuend minus zero-extended 8-bit
//                divisor, built as a ripple chain of full-adder cells with
//                the divisor inverted and carry-in tied to 1.
//  Ports       : i_minuend [8:0]  shifted partial remainder
//                i_divisor [7:0]  divisor
//                o_diff    [7:0]  low 8 bits of the difference
//                o_borrow         1 when minuend < divisor
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic w_axb;

    assign w_axb  = i_a ^ i_b;
    assign o_sum  = w_axb ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_axb);
endmodule : full_adder

module trial_subtractor
    import div_pkg::*;
(
    input  logic [c_DATA_W:0]   i_minuend,
    input  logic [c_DATA_W-1:0] i_divisor,
    output logic [c_DATA_W-1:0] o_diff,
    output logic                o_borrow
);
    logic [c_DATA_W:0] w_carry;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < c_DATA_W; gi++) begin : g_bit
            full_adder u_fa (
                .i_a    (i_minuend[gi]),
                .i_b    (~i_divisor[gi]),
                .i_cin  (w_carry[gi]),
                .o_sum  (o_diff[gi]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate

    // Top bit: the divisor's extension bit is 0, inverted to 1, so that
    // cell's carry-out reduces to (a | cin). Its sum bit is never needed
    // because a kept difference always fits in 8 bits.
    assign o_borrow = ~(i_minuend[c_DATA_W] | w_carry[c_DATA_W]);

endmodule : trial_subtractor

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : 8-bit unsigned sequential restoring divider, one quotient
//                bit per clock. FSM IDLE -> RUN (8 steps) -> DONE.
//  Ports       : Clk, Rst_n (sync, active-low), Start, Dividend[7:0],
//                Divisor[7:0] -> Quotient[7:0], Remainder[7:0], Busy, Done,
//                Div_by_zero (only when DIV_ZERO_FLAG_EN is defined).
//  Options     : DIV_ZERO_FLAG_EN - divide-by-zero short-cuts straight to
//                DONE with Quotient=FF, Remainder=Dividend and a flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Start,
    input  logic [c_DATA_W-1:0] Dividend,
    input  logic [c_DATA_W-1:0] Divisor,
    output logic [c_DATA_W-1:0] Quotient,
    output logic [c_DATA_W-1:0] Remainder,
    output logic                Busy,
`ifdef DIV_ZERO_FLAG_EN
    output logic                Div_by_zero,
`endif
    output logic                Done
);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_ITER - 1);

    state_t              r_state;
    logic [c_DATA_W-1:0] r_dvd;    // dividend bits shift out, quotient bits shift in
    logic [c_DATA_W-1:0] r_dsr;
    logic [c_DATA_W-1:0] r_rem;
    logic [c_CNT_W-1:0]  r_count;

    logic [c_DATA_W:0]   w_shift;
    logic [c_DATA_W-1:0] w_diff;
    logic                w_borrow;
    logic [c_DATA_W-1:0] w_next_rem;
    logic [c_DATA_W-1:0] w_next_q;

    assign w_shift    = {r_rem, r_dvd[c_DATA_W-1]};
    assign w_next_rem = w_borrow ? w_shift[c_DATA_W-1:0] : w_diff;
    assign w_next_q   = {r_dvd[c_DATA_W-2:0], ~w_borrow};

    trial_subtractor u_trial (
        .i_minuend (w_shift),
        .i_divisor (r_dsr),
        .o_diff    (w_diff),
        .o_borrow  (w_borrow)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            Div_by_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    Done        <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                    Div_by_zero <= 1'b0;
`endif
                    if (Start) begin
                        r_dvd   <= Dividend;
                        r_dsr   <= Divisor;
                        r_rem   <= '0;
                        r_count <= '0;
`ifdef DIV_ZERO_FLAG_EN
                        if (Divisor == '0) begin
                            r_state     <= S_DONE;
                            Quotient    <= '1;
                            Remainder   <= Dividend;
                            Done        <= 1'b1;
                            Div_by_zero <= 1'b1;
                            Busy        <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                            Busy    <= 1'b1;
                        end
`else
                        r_state <= S_RUN;
                        Busy    <= 1'b1;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    r_rem   <= w_next_rem;
                    r_dvd   <= w_next_q;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        Quotient  <= w_next_q;
                        Remainder <= w_next_rem;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule : seq_divider

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed self-checking bench for seq_divider. Follows the
//                DUT build option DIV_ZERO_FLAG_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Start;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
`ifdef DIV_ZERO_FLAG_EN
    logic       Div_by_zero;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_last_q = 8'h00;   // expected held Quotient

    seq_divider u_dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Start       (Start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Busy        (Busy),
`ifdef DIV_ZERO_FLAG_EN
        .Div_by_zero (Div_by_zero),
`endif
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Called right after the accepting edge. edges counts that edge as 1.
    task automatic wait_done(input bit scramble, output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = 0;
        while (!Done && edges < 30) begin
            if (Busy) busy_cnt++;
            if (scramble) begin
                Dividend = 8'($urandom);
                Divisor  = 8'($urandom);
            end
            tick();
            edges++;
        end
        check("done_timeout", 32'(Done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er);
        int   edges, busy_cnt, exp_lat, exp_busy;
        bit   fast;
        fast = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
        fast = (b == 8'd0);
`endif
        exp_lat  = fast ? 1 : 9;
        exp_busy = fast ? 0 : 8;
        Start = 1'b1; Dividend = a; Divisor = b;
        tick();
        Start = 1'b0;
        if (!fast) begin
            check({tag, "_busy_rise"}, 32'(Busy), 32'd1);
            check({tag, "_q_held"}, 32'(Quotient), 32'(m_last_q));
        end
        wait_done(1'b0, edges, busy_cnt);
        check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_quot"}, 32'(Quotient), 32'(eq));
        check({tag, "_rem"}, 32'(Remainder), 32'(er));
        check({tag, "_busy_low"}, 32'(Busy), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_dbz"}, 32'(Div_by_zero), 32'(fast));
`endif
        m_last_q = eq;
        tick();
        check({tag, "_done_pulse"}, 32'(Done), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_dbz_pulse"}, 32'(Div_by_zero), 32'd0);
`endif
        check({tag, "_quot_hold"}, 32'(Quotient), 32'(eq));
    endtask

    initial begin
        int  edges, busy_cnt;
        bit  saw_done;

        Rst_n = 1'b0; Start = 1'b0; Dividend = 8'd0; Divisor = 8'd0;
        repeat (3) tick();
        Rst_n = 1'b1;
        tick();
        check("rst_quot", 32'(Quotient), 32'd0);
        check("rst_rem", 32'(Remainder), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("rst_dbz", 32'(Div_by_zero), 32'd0);
`endif

        run_op("d200_7", 8'd200, 8'd7, 8'd28, 8'd4);
        run_op("d255_1", 8'd255, 8'd1, 8'hFF, 8'd0);
        run_op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5);
        run_op("d255_255", 8'd255, 8'd255, 8'd1, 8'd0);
        run_op("d42_0", 8'h42, 8'd0, 8'hFF, 8'h42);

        // Reset asserted on the 4th RUN edge aborts the operation.
        Start = 1'b1; Dividend = 8'd100; Divisor = 8'd3;
        tick();
        Start = 1'b0;
        repeat (3) tick();
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_quot", 32'(Quotient), 32'd0);
        check("abort_rem", 32'(Remainder), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Done || Busy) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        m_last_q = 8'h00;
        run_op("d100_3", 8'd100, 8'd3, 8'd33, 8'd1);

        // Start held through RUN with changing operands, then back-to-back.
        Start = 1'b1; Dividend = 8'd77; Divisor = 8'd5;
        tick();
        wait_done(1'b1, edges, busy_cnt);
        check("hold_latency", 32'(edges), 32'd9);
        check("hold_quot", 32'(Quotient), 32'd15);
        check("hold_rem", 32'(Remainder), 32'd2);
        Dividend = 8'd50; Divisor = 8'd6;
        tick();
        check("b2b_done_low", 32'(Done), 32'd0);
        check("b2b_busy", 32'(Busy), 32'd1);
        check("b2b_q_held", 32'(Quotient), 32'd15);
        Start = 1'b0;
        wait_done(1'b0, edges, busy_cnt);
        check("b2b_latency", 32'(edges), 32'd9);
        check("b2b_quot", 32'(Quotient), 32'd8);
        check("b2b_rem", 32'(Remainder), 32'd2);
        tick();
        check("b2b_done_pulse", 32'(Done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_divider

`default_nettype wire
